// File: rtl/hps_cmd_serializer.sv
// hps_cmd_serializer
//   Initiator side of the byte-wide HPS write port into the display block.
//   Takes one whole command per valid/ready handshake and plays it out as
//   a fixed sequence of 8-bit register writes:
//     render (type 0) : 6 beats, addr 0..5, cmd_data bytes MSB first
//     image  (type 1) : 7 beats, opcode 0xFD, RGB, then 20-bit pixel address
//     clear  (type 2) : 1 beat, addr 0, opcode 0xFE
//   Type 3, and renders whose first byte collides with an opcode (0xFD/0xFE),
//   are accepted but rejected: err pulses, no beats are issued.
// Ports:
//   clk50, reset_n              clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_type[1:0], cmd_data[47:0]  command, latched at acceptance
//   bus_waitrequest             receiver stall, holds the current beat
//   hps_writedata[7:0], hps_address[2:0], hps_write, hps_chipselect  write port
//   busy                        high from acceptance until the last beat completes
//   err                         one-cycle pulse after a rejected command
module hps_cmd_serializer #(
  parameter int GAP_CYCLES   = 0,
  parameter int PIXEL_ADDR_W = 20
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  input  logic [47:0] cmd_data,
  output logic        cmd_ready,
  input  logic        bus_waitrequest,
  output logic [7:0]  hps_writedata,
  output logic [2:0]  hps_address,
  output logic        hps_write,
  output logic        hps_chipselect,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [1:0] T_RENDER = 2'd0;
  localparam logic [1:0] T_IMAGE  = 2'd1;
  localparam logic [1:0] T_CLEAR  = 2'd2;
  localparam logic [1:0] T_BAD    = 2'd3;

  localparam logic [7:0] OP_IMAGE = 8'hFD;
  localparam logic [7:0] OP_CLEAR = 8'hFE;

  // Last value the gap counter reaches before returning to ISSUE.
  localparam int         GAP_M1   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_LAST = GAP_M1[3:0];

  logic [1:0]  state_reg;
  logic [2:0]  beat_reg;
  logic [3:0]  gap_cnt_reg;
  logic [1:0]  type_reg;
  logic [47:0] data_reg;
  logic        err_reg;

  logic        accept;
  logic        illegal;
  logic [2:0]  last_beat;
  logic [19:0] pix_addr;
  logic [7:0]  render_byte [6];
  logic [7:0]  beat_data;
  logic        issuing;

  assign accept  = cmd_valid && (state_reg == IDLE);
  assign illegal = (cmd_type == T_BAD) ||
                   ((cmd_type == T_RENDER) &&
                    ((cmd_data[47:40] == OP_IMAGE) || (cmd_data[47:40] == OP_CLEAR)));

  // Pixel address bits at or above PIXEL_ADDR_W are forced to zero.
  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_pix
      if (gi < PIXEL_ADDR_W) begin : g_on
        assign pix_addr[gi] = data_reg[24+gi];
      end else begin : g_off
        assign pix_addr[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < 6; gi++) begin : g_render
      assign render_byte[gi] = data_reg[47-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    last_beat = 3'd0;
    case (type_reg)
      T_RENDER: last_beat = 3'd5;
      T_IMAGE:  last_beat = 3'd6;
      default:  last_beat = 3'd0;
    endcase
  end

  always_comb begin
    beat_data = OP_CLEAR;
    case (type_reg)
      T_RENDER: beat_data = (beat_reg < 3'd6) ? render_byte[beat_reg] : 8'h00;
      T_IMAGE: begin
        case (beat_reg)
          3'd0:    beat_data = OP_IMAGE;
          3'd1:    beat_data = data_reg[23:16];
          3'd2:    beat_data = data_reg[15:8];
          3'd3:    beat_data = data_reg[7:0];
          3'd4:    beat_data = {4'b0000, pix_addr[19:16]};
          3'd5:    beat_data = pix_addr[15:8];
          default: beat_data = pix_addr[7:0];
        endcase
      end
      default: beat_data = OP_CLEAR;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      beat_reg    <= 3'd0;
      gap_cnt_reg <= 4'd0;
      type_reg    <= T_CLEAR;
      data_reg    <= 48'd0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= accept && illegal;
      case (state_reg)
        IDLE: begin
          if (accept && !illegal) begin
            type_reg  <= cmd_type;
            data_reg  <= cmd_data;
            beat_reg  <= 3'd0;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          // Beat address/data stay put while the receiver stalls.
          if (!bus_waitrequest) begin
            if (beat_reg == last_beat) begin
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_reg + 3'd1;
              if (GAP_CYCLES > 0) begin
                state_reg   <= GAP;
                gap_cnt_reg <= 4'd0;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= ISSUE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign issuing        = (state_reg == ISSUE);
  assign hps_write      = issuing;
  assign hps_chipselect = issuing;
  assign hps_address    = issuing ? beat_reg : 3'd0;
  assign hps_writedata  = issuing ? beat_data : 8'h00;
  assign cmd_ready      = (state_reg == IDLE);
  assign busy           = (state_reg != IDLE);
  assign err            = err_reg;

endmodule

// File: tb/tb_hps_cmd_serializer.sv
// Self-checking bench for hps_cmd_serializer.
// Two instances: u_dut0 with GAP_CYCLES=0, u_dut1 with GAP_CYCLES=2.
// Stimulus pushes expected beats (address, data, cycle) into per-instance
// queues; negedge monitors pop and compare every completed beat.
module tb_hps_cmd_serializer;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    int         c;
  } beat_t;

  logic clk50 = 1'b0;
  logic reset_n;

  logic        v0, r0, wr0, w0, cs0, b0, e0;
  logic [1:0]  t0;
  logic [47:0] d0;
  logic [7:0]  wd0;
  logic [2:0]  a0;

  logic        v1, r1, wr1, w1, cs1, b1, e1;
  logic [1:0]  t1;
  logic [47:0] d1;
  logic [7:0]  wd1;
  logic [2:0]  a1;

  beat_t q0[$];
  beat_t q1[$];

  int cyc = 0;
  int cmp = 0;
  int mis = 0;
  int wcount1 = 0;

  logic       held;
  logic [2:0] ha;
  logic [7:0] hd;

  logic [7:0] img_exp [7];
  logic [7:0] stall_exp [6];

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  hps_cmd_serializer #(.GAP_CYCLES(0), .PIXEL_ADDR_W(20)) u_dut0 (
    .clk50(clk50), .reset_n(reset_n), .cmd_valid(v0), .cmd_type(t0),
    .cmd_data(d0), .cmd_ready(r0), .bus_waitrequest(wr0),
    .hps_writedata(wd0), .hps_address(a0), .hps_write(w0),
    .hps_chipselect(cs0), .busy(b0), .err(e0)
  );

  hps_cmd_serializer #(.GAP_CYCLES(2), .PIXEL_ADDR_W(20)) u_dut1 (
    .clk50(clk50), .reset_n(reset_n), .cmd_valid(v1), .cmd_type(t1),
    .cmd_data(d1), .cmd_ready(r1), .bus_waitrequest(wr1),
    .hps_writedata(wd1), .hps_address(a1), .hps_write(w1),
    .hps_chipselect(cs1), .busy(b1), .err(e1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    cmp++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic exp_beat(input int sel, input logic [2:0] a, input logic [7:0] d, input int c);
    beat_t e;
    e.a = a; e.d = d; e.c = c;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Offer a command in the current cycle and return its acceptance cycle.
  // Inputs are scrambled afterwards to show they are latched.
  task automatic issue(input int sel, input logic [1:0] ty, input logic [47:0] data, output int t);
    if (sel == 0) begin
      chk("ready_at_accept0", r0, 1);
      v0 = 1'b1; t0 = ty; d0 = data;
    end else begin
      chk("ready_at_accept1", r1, 1);
      v1 = 1'b1; t1 = ty; d1 = data;
    end
    t = cyc;
    $display("cmd dut%0d type=%0d data=%012h accepted in cycle %0d", sel, ty, data, t);
    tick();
    if (sel == 0) begin v0 = 1'b0; t0 = 2'd3; d0 = ~data; end
    else          begin v1 = 1'b0; t1 = 2'd3; d1 = ~data; end
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? r0 : r1) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      cmp++; mis++;
      $display("FAIL wait_idle%0d: cmd_ready still low after %0d cycles, expected high", sel, budget);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_ready"}, r0, 1);
    chk({tag, "_write"}, w0, 0);
    chk({tag, "_cs"},    cs0, 0);
    chk({tag, "_data"},  wd0, 0);
    chk({tag, "_addr"},  a0, 0);
    chk({tag, "_busy"},  b0, 0);
    chk({tag, "_err"},   e0, 0);
  endtask

  // Monitor for the zero-gap instance.
  always @(negedge clk50) begin
    beat_t e;
    if (w0 && !wr0) begin
      chk("cs0_follows_write", cs0, w0);
      if (q0.size() == 0) begin
        cmp++; mis++;
        $display("FAIL unexpected_beat0: got addr=%0d data=%02h, expected no beat (cycle %0d)", a0, wd0, cyc);
      end else begin
        e = q0.pop_front();
        $display("beat dut0 cycle %0d addr=%0d data=%02h", cyc, a0, wd0);
        chk("beat0_addr",  a0, e.a);
        chk("beat0_data",  wd0, e.d);
        chk("beat0_cycle", cyc, e.c);
      end
    end
  end

  // Monitor for the gap instance, also checking a stalled beat holds.
  always @(negedge clk50) begin
    beat_t e;
    if (w1) wcount1 <= wcount1 + 1;
    if (held) begin
      chk("stall_hold_write", w1, 1);
      chk("stall_hold_addr",  a1, ha);
      chk("stall_hold_data",  wd1, hd);
    end
    held <= w1 && wr1;
    ha   <= a1;
    hd   <= wd1;
    if (w1 && !wr1) begin
      chk("cs1_follows_write", cs1, w1);
      if (q1.size() == 0) begin
        cmp++; mis++;
        $display("FAIL unexpected_beat1: got addr=%0d data=%02h, expected no beat (cycle %0d)", a1, wd1, cyc);
      end else begin
        e = q1.pop_front();
        $display("beat dut1 cycle %0d addr=%0d data=%02h", cyc, a1, wd1);
        chk("beat1_addr",  a1, e.a);
        chk("beat1_data",  wd1, e.d);
        chk("beat1_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, n;
    logic [1:0]  bad_t [3];
    logic [47:0] bad_d [3];

    img_exp   = '{8'hFD, 8'hAA, 8'hBB, 8'hCC, 8'h0F, 8'h12, 8'h34};
    stall_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    bad_t = '{2'd0, 2'd0, 2'd3};
    bad_d = '{48'hFE0102030405, 48'hFD0102030405, 48'h010203040506};

    held = 1'b0;
    reset_n = 1'b0;
    v0 = 0; t0 = 0; d0 = 0; wr0 = 0;
    v1 = 0; t1 = 0; d1 = 0; wr1 = 0;
    repeat (3) tick();
    chk_reset0("reset");
    chk("reset_ready1", r1, 1);
    chk("reset_busy1",  b1, 0);
    reset_n = 1'b1;
    tick();

    // Render: six beats T+1..T+6, ready again at T+7.
    issue(0, 2'd0, 48'h010203040506, t);
    for (int i = 0; i < 6; i++) exp_beat(0, 3'(i), 8'(i + 1), t + 1 + i);
    repeat (5) tick();
    chk("render_ready_T6", r0, 0);
    chk("render_busy_T6",  b0, 1);
    tick();
    chk("render_ready_T7", r0, 1);
    chk("render_busy_T7",  b0, 0);

    // Image write; upper nibble of cmd_data must not leak into beat 4.
    issue(0, 2'd1, 48'hAF1234AABBCC, t);
    for (int i = 0; i < 7; i++) exp_beat(0, 3'(i), img_exp[i], t + 1 + i);
    n = 0;
    for (int k = 0; k < 9; k++) begin
      if (b0) n++;
      tick();
    end
    chk("image_busy_cycles", n, 7);

    // Clear, then render accepted as early as possible.
    issue(0, 2'd2, 48'h123456789ABC, t);
    exp_beat(0, 3'd0, 8'hFE, t + 1);
    tick();
    issue(0, 2'd0, 48'h112233445566, t2);
    chk("clear_next_accept", t2, t + 2);
    for (int i = 0; i < 6; i++) exp_beat(0, 3'(i), 8'(8'h11 * (i + 1)), t2 + 1 + i);
    wait_idle(0, 20);

    // Rejected commands: err pulse, no beats, ready never drops.
    for (int k = 0; k < 3; k++) begin
      issue(0, bad_t[k], bad_d[k], t);
      chk("reject_err",   e0, 1);
      chk("reject_ready", r0, 1);
      chk("reject_busy",  b0, 0);
      tick();
      chk("reject_err_clear", e0, 0);
      chk("reject_ready2",    r0, 1);
    end

    // Gap instance: 2 idle cycles between beats, beat 2 stalled 3 cycles.
    issue(1, 2'd0, 48'hA1B2C3D4E5F6, t);
    exp_beat(1, 3'd0, stall_exp[0], t + 1);
    exp_beat(1, 3'd1, stall_exp[1], t + 4);
    exp_beat(1, 3'd2, stall_exp[2], t + 10);
    exp_beat(1, 3'd3, stall_exp[3], t + 13);
    exp_beat(1, 3'd4, stall_exp[4], t + 16);
    exp_beat(1, 3'd5, stall_exp[5], t + 19);
    repeat (6) tick();
    wr1 = 1'b1;
    repeat (3) tick();
    wr1 = 1'b0;
    wait_idle(1, 40);
    tick();
    chk("gap_write_cycles", wcount1, 9);

    // Reset during beat 3 of an image write aborts it.
    issue(0, 2'd1, 48'h0F1234AABBCC, t);
    for (int i = 0; i < 4; i++) exp_beat(0, 3'(i), img_exp[i], t + 1 + i);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    chk_reset0("midreset");
    reset_n = 1'b1;
    tick();
    issue(0, 2'd2, 48'h0, t);
    exp_beat(0, 3'd0, 8'hFE, t + 1);
    wait_idle(0, 10);

    repeat (3) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
